// File: rtl/imem_fetch_arbiter_pkg.sv
// Package imem_arb_pkg: shared types and helpers for the instruction/data memory
// arbiter slice.
//   arb_state_t : pending-response state (idle, fetch response due, data response due)
//   WORD_W      : memory word width in bits
//   STRB_W      : byte-enable width
//   addr_ok()   : legality of a byte address against a 2^addr_w word memory
package imem_arb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RSP_I = 2'd1,
    ARB_RSP_D = 2'd2
  } arb_state_t;

  // Legal when word aligned and the word index fits in addr_w bits.
  function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                   input int unsigned addr_w);
    logic [WORD_W-3:0] word;
    word = addr[WORD_W-1:2];
    return (addr[1:0] == 2'b00) && ((word >> addr_w) == '0);
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Interface imem_fetch_arbiter_if: bundles the fetch port, the load/store port and
// the memory-side port of the arbiter.
//   slave  modport : arbiter view (requests in, readies/responses/memory drive out)
//   master modport : core + memory view (the mirror image)
// Parameter ADDR_W sets the memory word-address width.
interface imem_fetch_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  // fetch port
  logic              if_req_valid;
  logic              if_req_ready;
  logic [WORD_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [WORD_W-1:0] if_rdata;
  logic              if_rsp_err;
  // load/store port
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [STRB_W-1:0] d_wstrb;
  logic [WORD_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [WORD_W-1:0] d_rdata;
  logic              d_rsp_err;
  // memory port
  logic              mem_en;
  logic [STRB_W-1:0] mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    input  d_req_valid, d_we, d_wstrb, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    output d_req_valid, d_we, d_wstrb, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_fetch_arbiter_grant_sel.sv
// Module arb_grant_sel: picks which request port owns the memory this cycle.
//   clk      in  clock (present only with ARB_STARVE_GUARD_EN)
//   reset    in  synchronous active-high reset; no grant while held
//   if_valid in  fetch request present
//   d_valid  in  data request present
//   grant_i  out fetch accepted this cycle
//   grant_d  out data accepted this cycle
// Data normally wins a tie. With macro ARB_STARVE_GUARD_EN defined, a saturating
// counter of data grants made while a fetch waits lets the fetch win the next tie
// once it reaches MAX_WAIT.
module arb_grant_sel #(
  parameter int unsigned MAX_WAIT = 4
) (
`ifdef ARB_STARVE_GUARD_EN
  input  logic clk,
`endif
  input  logic reset,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             fetch_wins;

  assign fetch_wins = (wait_cnt_reg == CNT_W'(MAX_WAIT));

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (d_valid && !(if_valid && fetch_wins)) grant_d = 1'b1;
      else if (if_valid)                        grant_i = 1'b1;
    end
  end

  // Only data grants that overtake a waiting fetch advance the count.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (grant_i || !if_valid)      wait_cnt_next = '0;
    else if (grant_d && !fetch_wins) wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_reg <= '0;
    else       wait_cnt_reg <= wait_cnt_next;
  end
`else
  always_comb begin
    grant_d = !reset && d_valid;
    grant_i = !reset && if_valid && !d_valid;
  end
`endif

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Module imem_fetch_arbiter: shares one single-port, 1-cycle-latency word memory
// between the read-only instruction fetch port and the load/store data port.
//   clk    in  single clock, rising edge
//   reset  in  synchronous, active-high
//   bus    slave modport of imem_fetch_arbiter_if (fetch port, data port,
//          memory port)
// Parameters: ADDR_W word-address width, MAX_WAIT starvation guard threshold.
// Optional feature: macro ARB_STARVE_GUARD_EN enables the fetch starvation guard.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic clk,
  input logic reset,
  imem_fetch_arbiter_if.slave bus
);

  logic              grant_i, grant_d, any_grant, sel_ok, store_en;
  logic [WORD_W-1:0] sel_addr;
  arb_state_t        state_reg, state_next;
  logic              err_reg, err_next;
  logic              store_reg, store_next;

  arb_grant_sel #(.MAX_WAIT(MAX_WAIT)) u_grant_sel (
`ifdef ARB_STARVE_GUARD_EN
    .clk      (clk),
`endif
    .reset    (reset),
    .if_valid (bus.if_req_valid),
    .d_valid  (bus.d_req_valid),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  assign bus.if_req_ready = grant_i;
  assign bus.d_req_ready  = grant_d;

  assign any_grant = grant_i | grant_d;
  assign sel_addr  = grant_d ? bus.d_addr : bus.if_addr;
  assign sel_ok    = addr_ok(sel_addr, ADDR_W);

  // Illegal requests are still accepted but never touch the memory.
  assign bus.mem_en    = any_grant & sel_ok;
  assign store_en      = grant_d & sel_ok & bus.d_we;
  assign bus.mem_addr  = any_grant ? sel_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = grant_d ? bus.d_wdata : '0;

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_we
      assign bus.mem_we[gi] = store_en & bus.d_wstrb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
      err_reg   <= 1'b0;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      store_reg <= store_next;
    end
  end

  // Next state depends only on this cycle's acceptance; responses are driven
  // from the registered state. Holding reset suppresses a response already due,
  // so a request accepted just before reset is silently dropped.
  always_comb begin
    state_next       = ARB_IDLE;
    err_next         = any_grant & ~sel_ok;
    store_next       = grant_d & bus.d_we;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_err   = 1'b0;
    bus.if_rdata     = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_err    = 1'b0;
    bus.d_rdata      = '0;

    if (grant_i)      state_next = ARB_RSP_I;
    else if (grant_d) state_next = ARB_RSP_D;

    if (!reset) begin
      case (state_reg)
        ARB_RSP_I: begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rsp_err   = err_reg;
          bus.if_rdata     = err_reg ? '0 : bus.mem_rdata;
        end
        ARB_RSP_D: begin
          bus.d_rsp_valid = 1'b1;
          bus.d_rsp_err   = err_reg;
          bus.d_rdata     = (err_reg || store_reg) ? '0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
